// File: rtl/pet_pkg.sv
// pet_pkg: shared types and constants for the pet-care button front end.
package pet_pkg;
  typedef enum logic [1:0] {IDLE, PRESS_WAIT, PRESSED, RELEASE_WAIT} ch_state_e;
  localparam int BTN_CARINO   = 0;
  localparam int BTN_DORMIR   = 1;
  localparam int BTN_COMIDA   = 2;
  localparam int BTN_MEDICINA = 3;
  localparam int DEBOUNCE_CYCLES_DFLT = 1_000_000;
  localparam int HOLD_CYCLES_DFLT     = 250_000_000;
endpackage

// File: rtl/debounce_channel.sv
// debounce_channel: synchronise, debounce and pulse-detect one active-low button.
module debounce_channel
  import pet_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DFLT,
  parameter int HOLD_CYCLES     = HOLD_CYCLES_DFLT
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_n,
  output logic level,
  output logic press,
  output logic hold
);
  localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int HW = $clog2(HOLD_CYCLES + 1);
  logic [1:0] sync_q;
  ch_state_e state_q, state_d;
  logic [DW-1:0] dcnt_q, dcnt_d;
  logic [HW-1:0] hcnt_q, hcnt_d;
  logic hold_done_q, hold_done_d;
  logic level_q, level_d, press_q, press_d, hold_q, hold_d;
  logic s, dterm, hterm;
  // Synchroniser resets to released so reset never fakes a press.
  assign s     = ~sync_q[1];
  assign dterm = dcnt_q == DW'(DEBOUNCE_CYCLES - 1);
  assign hterm = hcnt_q == HW'(HOLD_CYCLES - 1);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q      <= 2'b11;
      state_q     <= IDLE;
      dcnt_q      <= '0;
      hcnt_q      <= '0;
      hold_done_q <= 1'b0;
      level_q     <= 1'b0;
      press_q     <= 1'b0;
      hold_q      <= 1'b0;
    end else begin
      sync_q      <= {sync_q[0], btn_n};
      state_q     <= state_d;
      dcnt_q      <= dcnt_d;
      hcnt_q      <= hcnt_d;
      hold_done_q <= hold_done_d;
      level_q     <= level_d;
      press_q     <= press_d;
      hold_q      <= hold_d;
    end
  end
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:         state_d = s ? PRESS_WAIT : IDLE;
      PRESS_WAIT:   state_d = !s ? IDLE : dterm ? PRESSED : PRESS_WAIT;
      PRESSED:      state_d = s ? PRESSED : RELEASE_WAIT;
      RELEASE_WAIT: state_d = s ? PRESSED : dterm ? IDLE : RELEASE_WAIT;
      default:      state_d = IDLE;
    endcase
  end
  always_comb begin
    dcnt_d      = dcnt_q;
    hcnt_d      = hcnt_q;
    hold_done_d = hold_done_q;
    level_d     = level_q;
    press_d     = 1'b0;
    hold_d      = 1'b0;
    unique case (state_q)
      IDLE: if (s) dcnt_d = '0;
      PRESS_WAIT:
        if (s && dterm) begin
          level_d     = 1'b1;
          press_d     = 1'b1;
          hcnt_d      = '0;
          hold_done_d = 1'b0;
        end else if (s) dcnt_d = dcnt_q + DW'(1);
      PRESSED:
        if (!s) dcnt_d = '0;
        else if (!hold_done_q && hterm) begin
          hold_d      = 1'b1;
          hold_done_d = 1'b1;
        end else if (!hold_done_q) hcnt_d = hcnt_q + HW'(1);
      RELEASE_WAIT:
        if (!s && dterm) level_d = 1'b0;
        else if (!s) dcnt_d = dcnt_q + DW'(1);
      default: ;
    endcase
  end
  assign level = level_q;
  assign press = press_q;
  assign hold  = hold_q;
endmodule

// File: rtl/button_conditioner.sv
// button_conditioner: four independent debounced pet-care button channels.
module button_conditioner
  import pet_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DFLT,
  parameter int HOLD_CYCLES     = HOLD_CYCLES_DFLT
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] btn_n,
  output logic [3:0] level,
  output logic [3:0] press,
  output logic [3:0] hold
);
  for (genvar i = 0; i < 4; i++) begin : g_ch
    debounce_channel #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .HOLD_CYCLES    (HOLD_CYCLES)
    ) u_ch (
      .clk  (clk),
      .rst_n(rst_n),
      .btn_n(btn_n[i]),
      .level(level[i]),
      .press(press[i]),
      .hold (hold[i])
    );
  end
endmodule

// File: tb/tb_button_conditioner.sv
// tb_button_conditioner: directed checks of debounce, press, hold and reset behaviour.
module tb_button_conditioner;
  logic clk, rst_n;
  logic [3:0] btn_n, level, press, hold;
  int vectors = 0;
  int miscompares = 0;

  button_conditioner #(.DEBOUNCE_CYCLES(4), .HOLD_CYCLES(16)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .btn_n(btn_n),
    .level(level),
    .press(press),
    .hold (hold)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [3:0] l, input logic [3:0] p, input logic [3:0] h);
    vectors++;
    assert ({level, press, hold} === {l, p, h}) else begin
      miscompares++;
      $error("FAIL %s: level/press/hold got %h/%h/%h expected %h/%h/%h", tag, level, press, hold, l, p, h);
    end
  endtask

  task automatic run(input int n, input string tag, input logic [3:0] l, input logic [3:0] p, input logic [3:0] h);
    for (int k = 0; k < n; k++) begin
      tick();
      chk(tag, l, p, h);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    btn_n = 4'hF;
    tick();
    tick();
    chk("reset", 4'h0, 4'h0, 4'h0);
    rst_n = 1'b1;
    run(50, "idle", 4'h0, 4'h0, 4'h0);
    // Bit 0: low for edges 0..9, accepted at edge 6, released edge 10, falls at edge 16.
    btn_n = 4'b1110;
    run(6, "b0_wait", 4'h0, 4'h0, 4'h0);
    run(1, "b0_press", 4'h1, 4'h1, 4'h0);
    run(3, "b0_held", 4'h1, 4'h0, 4'h0);
    btn_n = 4'hF;
    run(6, "b0_relwait", 4'h1, 4'h0, 4'h0);
    run(4, "b0_released", 4'h0, 4'h0, 4'h0);
    // Bit 2: three-cycle glitch is rejected.
    btn_n = 4'b1011;
    run(3, "b2_glitch", 4'h0, 4'h0, 4'h0);
    btn_n = 4'hF;
    run(10, "b2_reject", 4'h0, 4'h0, 4'h0);
    // Bit 3: held edges 0..29, press at 6, single hold at 22, falls at 36.
    btn_n = 4'b0111;
    run(6, "b3_wait", 4'h0, 4'h0, 4'h0);
    run(1, "b3_press", 4'h8, 4'h8, 4'h0);
    run(15, "b3_held", 4'h8, 4'h0, 4'h0);
    run(1, "b3_hold", 4'h8, 4'h0, 4'h8);
    run(7, "b3_after_hold", 4'h8, 4'h0, 4'h0);
    btn_n = 4'hF;
    run(6, "b3_relwait", 4'h8, 4'h0, 4'h0);
    run(4, "b3_released", 4'h0, 4'h0, 4'h0);
    // Bit 1: accepted press, then release bounce high 2 / low 1 / high; falls at edge 17.
    btn_n = 4'b1101;
    run(6, "b1_wait", 4'h0, 4'h0, 4'h0);
    run(1, "b1_press", 4'h2, 4'h2, 4'h0);
    run(1, "b1_held", 4'h2, 4'h0, 4'h0);
    btn_n = 4'hF;
    run(2, "b1_bounce_hi", 4'h2, 4'h0, 4'h0);
    btn_n = 4'b1101;
    run(1, "b1_bounce_lo", 4'h2, 4'h0, 4'h0);
    btn_n = 4'hF;
    run(6, "b1_relwait", 4'h2, 4'h0, 4'h0);
    run(4, "b1_released", 4'h0, 4'h0, 4'h0);
    // Bits 0 and 3 together, reset mid-press, then fresh acceptance.
    btn_n = 4'b0110;
    run(6, "b03_wait", 4'h0, 4'h0, 4'h0);
    run(1, "b03_press", 4'h9, 4'h9, 4'h0);
    run(3, "b03_held", 4'h9, 4'h0, 4'h0);
    rst_n = 1'b0;
    #1;
    chk("async_reset", 4'h0, 4'h0, 4'h0);
    run(2, "in_reset", 4'h0, 4'h0, 4'h0);
    rst_n = 1'b1;
    run(6, "post_rst_wait", 4'h0, 4'h0, 4'h0);
    run(1, "post_rst_press", 4'h9, 4'h9, 4'h0);
    run(2, "post_rst_held", 4'h9, 4'h0, 4'h0);
    btn_n = 4'hF;
    run(6, "post_rst_relwait", 4'h9, 4'h0, 4'h0);
    run(2, "post_rst_released", 4'h0, 4'h0, 4'h0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/button_conditioner.md
# button_conditioner

Front-end conditioner for the four pet-care push buttons (cariño, dormir, comida, medicina). It synchronises the raw active-low board buttons and debounces each one independently. It produces clean active-high held levels for the pet-state block's `Carino`/`Dormir`/`Comida`/`Medicina` inputs, plus one-cycle press and long-hold pulses for menu/test logic. It sits directly between the FPGA pins and the pet-state block, in the same `clk` domain.

## Interface
- `DEBOUNCE_CYCLES`, default 1_000_000 (20 ms at 50 MHz): consecutive stable synchronised samples required to accept a press or release; must be ≥1.
- `HOLD_CYCLES`, default 250_000_000 (5 s): cycles a press must stay accepted before the hold pulse; must be ≥1.
- `clk` in 1: system clock, rising edge.
- `rst_n` in 1: reset, asynchronous and active-low.
- `btn_n` in 4: raw buttons, active-low, asynchronous. Bit 0 = cariño, 1 = dormir, 2 = comida, 3 = medicina.
- `level` out 4: debounced held state, active-high, same bit order.
- `press` out 4: one-cycle pulse when a press is accepted.
- `hold` out 4: one-cycle pulse once per press after `HOLD_CYCLES` accepted.

## Operation
- Four identical, fully independent channels; no interaction between bits.
- Each channel uses a 2-flop synchroniser on `btn_n[i]`. Both flops reset to 1 (released). `s = ~sync_out` (active-high pressed).
- Debounce FSM per channel: IDLE, PRESS_WAIT, PRESSED, RELEASE_WAIT.
  - IDLE: `s=1` → PRESS_WAIT, `dcnt<=0`.
  - PRESS_WAIT: `s=0` → IDLE (glitch rejected, no output change). `s=1` and `dcnt==DEBOUNCE_CYCLES-1` → PRESSED, `level<=1`, `press<=1`, `hcnt<=0`, `hold_done<=0`. Otherwise `dcnt++`.
  - PRESSED: `s=0` → RELEASE_WAIT, `dcnt<=0`. Otherwise, if `!hold_done`: when `hcnt==HOLD_CYCLES-1`, `hold<=1` and `hold_done<=1`; else `hcnt++`.
  - RELEASE_WAIT: `s=1` → PRESSED (bounce; `hcnt`/`hold_done` keep their values, counting resumes). `s=0` and `dcnt==DEBOUNCE_CYCLES-1` → IDLE, `level<=0`. Otherwise `dcnt++`.
- `press`/`hold` are registered and cleared every cycle they are not set.
- Counter widths: `dcnt` is `$clog2(DEBOUNCE_CYCLES+1)`; `hcnt` is `$clog2(HOLD_CYCLES+1)`. Neither counter wraps: a counter only reaches its terminal value inside the state that consumes it.
- Reset values: state IDLE, counters 0, `hold_done` 0, `level=0`, `press=0`, `hold=0`.
- Reset asserted mid-press: all outputs drop to 0 immediately (asynchronously). After release of reset, a still-held button is re-accepted through the full debounce and produces a fresh `press`.

## Timing
- Edge 0 is the first rising edge that samples `btn_n[i]=0`. Synchroniser output is low after edge 1. PRESS_WAIT is entered at edge 2.
- Press accepted: `level` rises and `press` pulses after edge 2+DEBOUNCE_CYCLES, provided the input stayed low throughout.
- Release: symmetric; `level` falls after edge 2+DEBOUNCE_CYCLES counted from the first high sample. No pulse is generated on release.
- Hold: `hold` pulses after edge 2+DEBOUNCE_CYCLES+HOLD_CYCLES, exactly once per accepted press.
- Simultaneous presses on several bits produce pulses in the same cycle.

## Structure
- Package `pet_pkg`:
  - channel-state enum (IDLE/PRESS_WAIT/PRESSED/RELEASE_WAIT);
  - bit-index constants `BTN_CARINO=0`, `BTN_DORMIR=1`, `BTN_COMIDA=2`, `BTN_MEDICINA=3`;
  - default `DEBOUNCE_CYCLES`/`HOLD_CYCLES`.
- One sub-module, `debounce_channel` (synchroniser + FSM + counters, single-bit I/O). The top instantiates it 4× via generate.

## Test plan
All scenarios use `DEBOUNCE_CYCLES=4`, `HOLD_CYCLES=16`.
- Reset release, all `btn_n=4'hF` for 50 cycles → `level=0`, `press=0`, `hold=0` throughout.
- `btn_n[0]` low at edge 0, held 10 cycles → `level[0]` rises and `press[0]` pulses 1 cycle after edge 6. Other bits stay 0.
- `btn_n[2]` low for 3 cycles, then high → no change on `level`, `press` or `hold`.
- `btn_n[3]` held 30 cycles → `press[3]` after edge 6, `hold[3]` single pulse after edge 22, no second pulse. After release, `level[3]` falls 6 cycles after the first high sample.
- Accepted press on bit 1, then release bounces (high 2 cycles, low 1 cycle, high) → `level[1]` stays 1 until 4 stable low samples. No extra `press`.
- Bits 0 and 3 pressed together, `rst_n` pulsed low at cycle 10 while still held → outputs 0 immediately. After reset release, `press[0]` and `press[3]` re-pulse 6 edges after the first post-reset sample.
